// File: rtl/instruction_fetch_unit.sv
// Fetch stage for a read-only instruction memory. Owns the PC and drives
// Address. Each returned word is captured with its PC into a 2-entry queue.
// The queue head goes to decode over a valid/ready handshake. Redirects and
// exceptions flush the queue and retarget the PC.
//
// Handshake: a deq happens on a rising edge where InstrValid && InstrReady.
// The producer (this block) holds Instr/InstrPC stable while InstrValid is
// high and not accepted. A new word is enqueued on an edge when the queue has
// room, or when it is full and a deq frees a slot on that same edge.
module instruction_fetch_unit #(
  parameter logic [31:0] ResetVector     = 32'h00000000,
  parameter logic [31:0] ExceptionVector = 32'hF0000000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Data,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Exception,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] FetchCount
);

  logic [31:0] r_pc;
  logic [31:0] r_fifo_pc   [0:1];
  logic [31:0] r_fifo_word [0:1];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic [31:0] r_fetch_count;

  logic        w_deq;
  logic        w_enq;
  logic        w_flush;
  logic [31:0] w_redirect_pc;

  // The low two bits of a redirect target are ignored, so the PC stays
  // word-aligned.
  assign w_redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  assign InstrValid = (r_count != 2'd0);
  assign w_deq      = InstrValid && InstrReady;
  assign w_flush    = Exception || Redirect;
  assign w_enq      = (r_count != 2'd2) || w_deq;

  assign Address    = r_pc;
  assign Instr      = r_fifo_word[r_head];
  assign InstrPC    = r_fifo_pc[r_head];
  assign FetchCount = r_fetch_count;

  // PC, queue, and handshake counter. A flush discards the word fetched
  // this cycle, but a deq on the same edge still completes and is counted.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc           <= ResetVector;
      r_fifo_pc[0]   <= 32'h0;
      r_fifo_pc[1]   <= 32'h0;
      r_fifo_word[0] <= 32'h0;
      r_fifo_word[1] <= 32'h0;
      r_head         <= 1'b0;
      r_tail         <= 1'b0;
      r_count        <= 2'd0;
      r_fetch_count  <= 32'h0;
    end else begin
      if (w_deq) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (Exception) begin
        r_pc    <= ExceptionVector;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_count <= 2'd0;
      end else if (Redirect) begin
        r_pc    <= w_redirect_pc;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_enq) begin
          r_fifo_pc[r_tail]   <= r_pc;
          r_fifo_word[r_tail] <= Data;
          r_tail              <= ~r_tail;
          r_pc                <= r_pc + 32'd4;
        end
        if (w_deq) begin
          r_head <= ~r_head;
        end
        r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      end
    end
  end

  // w_flush is only a readable summary for checkers; the priority chain
  // above decides what actually happens.
  logic w_unused;
  assign w_unused = w_flush;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] Data;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Exception;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] FetchCount;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Address    (Address),
    .Data       (Data),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Exception  (Exception),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .FetchCount (FetchCount)
  );

  // Clock: 30 ns period.
  initial CLK = 1'b0;
  always #15 CLK = ~CLK;

  // Instruction memory image.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3408_0032;
      32'h0000_0004: return 32'hac08_0000;
      32'h0000_0008: return 32'h3408_0028;
      32'h0000_000C: return 32'h0000_000C;
      32'h0000_0060: return 32'h6060_6060;
      32'h0000_0180: return 32'h3409_feed;
      32'h0000_0184: return 32'h3408_0190;
      32'hF000_0000: return 32'h8c08_0000;
      32'hFFFF_FFFC: return 32'h0000_0013;
      default:       return ~a;
    endcase
  endfunction

  assign Data = mem_read(Address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    check("rst_valid", {31'b0, InstrValid}, 32'h0);
    check("rst_addr", Address, 32'h0);
    check("rst_count", FetchCount, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    Exception  = 1'b0;
    InstrReady = 1'b0;
    #2;
    check("init_addr", Address, 32'h0);
    check("init_valid", {31'b0, InstrValid}, 32'h0);
    check("init_instr", Instr, 32'h0);
    check("init_pc", InstrPC, 32'h0);
    check("init_count", FetchCount, 32'h0);

    // 1: streaming
    InstrReady = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    step();
    check("s1_valid0", {31'b0, InstrValid}, 32'h1);
    check("s1_pc0", InstrPC, 32'h0);
    check("s1_instr0", Instr, 32'h3408_0032);
    check("s1_addr0", Address, 32'h4);
    step();
    check("s1_pc1", InstrPC, 32'h4);
    check("s1_instr1", Instr, 32'hac08_0000);
    check("s1_addr1", Address, 32'h8);
    check("s1_cnt1", FetchCount, 32'h1);
    step();
    check("s1_pc2", InstrPC, 32'h8);
    check("s1_instr2", Instr, 32'h3408_0028);
    check("s1_addr2", Address, 32'hC);
    step();
    check("s1_cnt3", FetchCount, 32'h3);

    // 2: backpressure
    InstrReady = 1'b0;
    do_reset();
    step();
    check("s2_addr_e0", Address, 32'h4);
    step();
    check("s2_addr_e1", Address, 32'h8);
    check("s2_instr_e1", Instr, 32'h3408_0032);
    step();
    check("s2_addr_frozen", Address, 32'h8);
    check("s2_instr_hold", Instr, 32'h3408_0032);
    check("s2_cnt_hold", FetchCount, 32'h0);
    InstrReady = 1'b1;
    check("s2_out0", Instr, 32'h3408_0032);
    step();
    check("s2_out1", Instr, 32'hac08_0000);
    check("s2_out1_pc", InstrPC, 32'h4);
    check("s2_addr_resume", Address, 32'hC);
    step();
    check("s2_out2", Instr, 32'h3408_0028);
    check("s2_out2_pc", InstrPC, 32'h8);
    check("s2_cnt2", FetchCount, 32'h2);

    // 3: redirect with a full queue
    InstrReady = 1'b0;
    do_reset();
    step();
    step();
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0183;
    step();
    Redirect   = 1'b0;
    InstrReady = 1'b1;
    check("s3_bubble", {31'b0, InstrValid}, 32'h0);
    check("s3_addr", Address, 32'h180);
    step();
    check("s3_valid", {31'b0, InstrValid}, 32'h1);
    check("s3_pc0", InstrPC, 32'h180);
    check("s3_instr0", Instr, 32'h3409_feed);
    step();
    check("s3_pc1", InstrPC, 32'h184);
    check("s3_instr1", Instr, 32'h3408_0190);
    check("s3_cnt", FetchCount, 32'h1);

    // 4: exception beats redirect; the same-cycle deq still counts
    Exception  = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0060;
    step();
    Exception = 1'b0;
    Redirect  = 1'b0;
    check("s4_bubble", {31'b0, InstrValid}, 32'h0);
    check("s4_addr", Address, 32'hF000_0000);
    check("s4_cnt", FetchCount, 32'h2);
    step();
    check("s4_pc", InstrPC, 32'hF000_0000);
    check("s4_instr", Instr, 32'h8c08_0000);
    step();
    check("s4_pc_next", InstrPC, 32'hF000_0004);

    // 5: asynchronous reset mid-stream
    step();
    step();
    check("s5_pre_cnt", FetchCount, 32'h5);
    check("s5_pre_valid", {31'b0, InstrValid}, 32'h1);
    #5;
    Reset = 1'b1;
    #1;
    check("s5_valid", {31'b0, InstrValid}, 32'h0);
    check("s5_addr", Address, 32'h0);
    check("s5_cnt", FetchCount, 32'h0);
    #3;
    Reset = 1'b0;
    step();
    check("s5_pc", InstrPC, 32'h0);
    check("s5_instr", Instr, 32'h3408_0032);

    // 6: PC wrap
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    check("s6_addr_tgt", Address, 32'hFFFF_FFFC);
    step();
    check("s6_addr_wrap", Address, 32'h0);
    check("s6_pc0", InstrPC, 32'hFFFF_FFFC);
    check("s6_instr0", Instr, 32'h0000_0013);
    step();
    check("s6_pc1", InstrPC, 32'h0);
    check("s6_instr1", Instr, 32'h3408_0032);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
